// File: rtl/raw_frame_to_gray_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : raw_frame_to_gray_stream
// Description : Streams one WIDTHxHEIGHT raw frame from a source FIFO into a
//               destination FIFO as rounded/saturated gray pixels with sof/eol.
//               Optional macro GRAY_SUM_EN adds the frame_sum output.
// Revision    : 1.0 - initial release
// ============================================================================
module raw_frame_to_gray_stream #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int RAW_W  = 10,
   parameter int GRAY_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              src_empty,
   output logic              read_en,
   input  logic [RAW_W-1:0]  raw_data,
   input  logic              dst_full,
   output logic              write_en,
   output logic [GRAY_W-1:0] gray_data,
   output logic              sof,
   output logic              eol,
   output logic              busy,
   output logic              finished
`ifdef GRAY_SUM_EN
   ,
   output logic [GRAY_W+$clog2(WIDTH*HEIGHT+1)-1:0] frame_sum
`endif
);

   localparam int c_TOTAL = WIDTH * HEIGHT;
   localparam int c_CNT_W = $clog2(c_TOTAL + 1);
   localparam int c_COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int c_SH    = RAW_W - GRAY_W;
   localparam int c_SUM_W = GRAY_W + c_CNT_W;

   localparam logic [c_CNT_W-1:0] c_CNT_TOTAL = c_CNT_W'(c_TOTAL);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_TOTAL - 1);
   localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(WIDTH - 1);
   localparam logic [RAW_W:0]     c_HALF      = (RAW_W+1)'(1) << (c_SH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_rd_cnt;
   logic [c_CNT_W-1:0]   r_wr_cnt;
   logic [c_COL_W-1:0]   r_col;
   logic [1:0]           r_occ;
   logic                 r_inflight;
   logic [GRAY_W-1:0]    r_buf0;
   logic [GRAY_W-1:0]    r_buf1;
   logic [c_SUM_W-1:0]   r_sum;

   logic [RAW_W:0]       w_rnd;
   logic [RAW_W:0]       w_shf;
   logic [GRAY_W-1:0]    w_gray;
   logic [2:0]           w_credit;

   assign w_rnd  = {1'b0, raw_data} + c_HALF;
   assign w_shf  = w_rnd >> c_SH;
   assign w_gray = (|w_shf[RAW_W:GRAY_W]) ? {GRAY_W{1'b1}} : w_shf[GRAY_W-1:0];

   assign busy      = (r_state == S_RUN);
   assign finished  = (r_state == S_DONE);
   assign write_en  = (r_occ != 2'd0) & ~dst_full;
   assign gray_data = r_buf0;
   assign sof       = write_en & (r_wr_cnt == '0);
   assign eol       = write_en & (r_col == c_COL_LAST);

   // Credit: slots already committed (held + returning) minus the one leaving now.
   assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, write_en};
   assign read_en  = busy & ~src_empty & (r_rd_cnt < c_CNT_TOTAL) & (w_credit < 3'd2);

`ifdef GRAY_SUM_EN
   assign frame_sum = r_sum;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rd_cnt   <= '0;
         r_wr_cnt   <= '0;
         r_col      <= '0;
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
         r_buf0     <= '0;
         r_buf1     <= '0;
         r_sum      <= '0;
      end else begin
         r_inflight <= read_en;
         if (read_en)
            r_rd_cnt <= r_rd_cnt + 1'b1;

         case ({r_inflight, write_en})
            2'b10: begin
               if (r_occ == 2'd0) r_buf0 <= w_gray;
               else               r_buf1 <= w_gray;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               if (r_occ == 2'd2) r_buf0 <= r_buf1;
               r_occ <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd2) begin
                  r_buf0 <= r_buf1;
                  r_buf1 <= w_gray;
               end else begin
                  r_buf0 <= w_gray;
               end
            end
            default: ;
         endcase

         if (write_en) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            r_col    <= (r_col == c_COL_LAST) ? '0 : r_col + 1'b1;
            r_sum    <= r_sum + c_SUM_W'(r_buf0);
         end

         case (r_state)
            S_RUN: begin
               if (write_en && (r_wr_cnt == c_CNT_LAST))
                  r_state <= S_DONE;
            end
            default: begin
               if (start) begin
                  r_state    <= S_RUN;
                  r_rd_cnt   <= '0;
                  r_wr_cnt   <= '0;
                  r_col      <= '0;
                  r_occ      <= 2'd0;
                  r_inflight <= 1'b0;
                  r_buf0     <= '0;
                  r_buf1     <= '0;
                  r_sum      <= '0;
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_raw_frame_to_gray_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_raw_frame_to_gray_stream
// Description : Directed-vector bench for raw_frame_to_gray_stream (4x2 frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raw_frame_to_gray_stream;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int RW = 10;
   localparam int GW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          src_empty = 1'b0;
   logic          dst_full = 1'b0;
   logic [RW-1:0] raw_data = '0;
   logic          read_en, write_en, sof, eol, busy, finished;
   logic [GW-1:0] gray_data;
`ifdef GRAY_SUM_EN
   logic [GW+$clog2(W*H+1)-1:0] frame_sum;
`endif

   raw_frame_to_gray_stream #(
      .WIDTH(W), .HEIGHT(H), .RAW_W(RW), .GRAY_W(GW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .src_empty(src_empty),
      .read_en(read_en), .raw_data(raw_data), .dst_full(dst_full),
      .write_en(write_en), .gray_data(gray_data), .sof(sof), .eol(eol),
      .busy(busy), .finished(finished)
`ifdef GRAY_SUM_EN
      , .frame_sum(frame_sum)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int src_q[$];
   int out_g[$];
   int out_s[$];
   int out_e[$];
   int rd_total = 0;
   int viol = 0;
   int cyc = 0;
   int last_wr_cyc = 0;

   // Source FIFO model: data appears the cycle after the pop.
   always @(posedge clk) begin
      if (read_en) begin
         rd_total++;
         if (src_q.size() > 0) raw_data <= RW'(src_q.pop_front());
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (write_en) begin
         out_g.push_back(int'(gray_data));
         out_s.push_back(int'(sof));
         out_e.push_back(int'(eol));
         last_wr_cyc = cyc;
      end
      if (read_en && src_empty) viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      tick;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic prep(input int raw [8]);
      src_q.delete();
      out_g.delete();
      out_s.delete();
      out_e.delete();
      for (int i = 0; i < 8; i++) src_q.push_back(raw[i]);
      rd_total = 0;
   endtask

   task automatic wait_writes(input int n);
      int k = 0;
      while (out_g.size() < n && k < 100) begin
         @(negedge clk);
         k++;
      end
      #1;
      check("wr_wait", out_g.size() >= n, 1);
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!finished && k < 300) begin
         @(negedge clk);
         k++;
      end
      #1;
      check({tag, "_done"}, finished, 1);
   endtask

   task automatic check_frame(input string tag, input int exp [8]);
      check({tag, "_cnt"}, out_g.size(), 8);
      check({tag, "_reads"}, rd_total, 8);
      for (int i = 0; i < 8; i++) begin
         if (i < out_g.size()) begin
            check($sformatf("%s_gray%0d", tag, i), out_g[i], exp[i]);
            check($sformatf("%s_sof%0d", tag, i), out_s[i], (i == 0) ? 1 : 0);
            check($sformatf("%s_eol%0d", tag, i), out_e[i], (i % W == W - 1) ? 1 : 0);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      repeat (3) tick;
      @(negedge clk);
      check("rst_read_en", read_en, 0);
      check("rst_write_en", write_en, 0);
      check("rst_gray", gray_data, 0);
      check("rst_sof", sof, 0);
      check("rst_eol", eol, 0);
      check("rst_busy", busy, 0);
      check("rst_finished", finished, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic frame: rounding 10->8 bits, latency, markers
      prep('{0, 1, 2, 3, 4, 5, 6, 7});
      pulse_start;
      @(negedge clk);
      check("busy_after_start", busy, 1);
      k = 0;
      while (!write_en && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("first_write_lat", k, 2);
      wait_done("f1");
      check("fin_lat", cyc - last_wr_cyc, 1);
      check_frame("f1", '{0, 0, 1, 1, 1, 1, 2, 2});
      check("f1_busy_end", busy, 0);

      // Saturation, start ignored during RUN, restart from DONE
      prep('{1023, 1022, 1021, 5, 0, 1, 2, 3});
      pulse_start;
      wait_writes(1);
      pulse_start;
      wait_done("f2");
      check_frame("f2", '{255, 255, 255, 1, 0, 0, 1, 1});

      // Destination backpressure for 5 cycles
      prep('{40, 44, 48, 52, 56, 60, 64, 68});
      pulse_start;
      wait_writes(3);
      @(posedge clk);
      #1;
      dst_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("full_no_write", write_en, 0);
      end
      check("full_credit", rd_total - out_g.size(), 2);
      @(posedge clk);
      #1;
      dst_full = 1'b0;
      wait_done("f3");
      check_frame("f3", '{10, 11, 12, 13, 14, 15, 16, 17});

      // Source empty toggling every cycle
      prep('{80, 84, 88, 92, 96, 100, 104, 108});
      viol = 0;
      pulse_start;
      k = 0;
      while (!finished && k < 300) begin
         tick;
         src_empty = ~src_empty;
         k++;
      end
      src_empty = 1'b0;
      wait_done("f4");
      check("f4_read_while_empty", viol, 0);
      check_frame("f4", '{20, 21, 22, 23, 24, 25, 26, 27});

      // Reset mid-frame, then a clean frame
      prep('{120, 124, 128, 132, 136, 140, 144, 148});
      pulse_start;
      wait_writes(3);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_finished", finished, 0);
      check("mid_rst_write_en", write_en, 0);
      check("mid_rst_read_en", read_en, 0);
      check("mid_rst_gray", gray_data, 0);
      prep('{160, 164, 168, 172, 176, 180, 184, 188});
      pulse_start;
      wait_done("f5");
      check_frame("f5", '{40, 41, 42, 43, 44, 45, 46, 47});

      // All-max frame
      prep('{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023});
      pulse_start;
      wait_done("f6");
      check_frame("f6", '{255, 255, 255, 255, 255, 255, 255, 255});
`ifdef GRAY_SUM_EN
      check("frame_sum", frame_sum, 2040);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
